// File: rtl/eight_to_three_encoder.sv
// eight_to_three_encoder: synchronised, debounced 8-to-3 priority encoder with a valid/ack handshake
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   EN         : synchronous encoder enable
//   in_I[7:0]  : raw asynchronous request lines, bit 7 highest priority
//   in_ack     : consumer acknowledge, honoured only while out_valid=1
//   out_Y[2:0] : latched code of the highest debounced request
//   out_valid  : out_Y is valid and not yet acknowledged
//   out_strobe : one-cycle pulse when out_valid rises
//   out_GS     : any debounced request high
module eight_to_three_encoder #(
    parameter int unsigned DB_CYCLES = 20'd1_000_000,
    parameter int unsigned CW = $clog2(DB_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [7:0] in_I,
    input  logic       in_ack,
    output logic [2:0] out_Y,
    output logic       out_valid,
    output logic       out_strobe,
    output logic       out_GS
);
    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, RELEASE} state_t;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    logic [7:0] meta_q, sync_q, db_q, db_d;
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];
    logic [2:0] y_q, y_d, code;
    state_t state_q, state_d;
    // A counter only runs while the synchronised level disagrees with the accepted one,
    // so any disagreement shorter than DB_CYCLES cycles is discarded.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = (sync_q[i] == db_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CW'(1);
            db_d[i] = (sync_q[i] != db_q[i] && cnt_q[i] == LAST) ? sync_q[i] : db_q[i];
        end
    end
    always_comb begin
        code = '0;
        for (int i = 0; i < 8; i++)
            if (db_q[i]) code = 3'(i);
    end
    always_comb begin
        state_d = state_q;
        y_d = y_q;
        case (state_q)
            IDLE: if (|db_q) begin
                state_d = CAPTURE;
                y_d = code;
            end
            CAPTURE: state_d = in_ack ? RELEASE : HOLD;
            HOLD: state_d = in_ack ? RELEASE : HOLD;
            RELEASE: state_d = |db_q ? RELEASE : IDLE;
        endcase
        if (!EN) begin
            state_d = IDLE;
            y_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            db_q <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            state_q <= IDLE;
            y_q <= '0;
        end else begin
            meta_q <= in_I;
            sync_q <= meta_q;
            db_q <= db_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            y_q <= y_d;
        end
    end
    assign out_Y = y_q;
    assign out_valid = (state_q == CAPTURE) || (state_q == HOLD);
    assign out_strobe = state_q == CAPTURE;
    assign out_GS = |db_q;
endmodule

// File: tb/tb_eight_to_three_encoder.sv
// tb_eight_to_three_encoder: scoreboard bench for eight_to_three_encoder with DB_CYCLES=4
module tb_eight_to_three_encoder;
    logic clk = 0, rst_n = 0, EN = 1, in_ack = 0;
    logic [7:0] in_I = 8'hFF;
    logic [2:0] out_Y;
    logic out_valid, out_strobe, out_GS;
    int errors = 0, checks = 0, strobes = 0;
    logic [2:0] exp_q [$];
    eight_to_three_encoder #(.DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .in_I(in_I), .in_ack(in_ack),
        .out_Y(out_Y), .out_valid(out_valid), .out_strobe(out_strobe), .out_GS(out_GS)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) if (out_strobe) begin
        strobes++;
        if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else chk("sb_code", 32'(out_Y), 32'(exp_q.pop_front()));
    end
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_strobe(input string tag);
        bit seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            seen = out_strobe;
        end
        if (!seen) chk(tag, 0, 1);
    endtask
    task automatic ack();
        in_ack = 1;
        cycles(1);
        in_ack = 0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int s0;
        bit gs_seen, v_seen;
        #12;
        chk("rst_Y", 32'(out_Y), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_strobe", 32'(out_strobe), 0);
        chk("rst_GS", 32'(out_GS), 0);
        in_I = 0;
        @(negedge clk) rst_n = 1;
        cycles(5);
        chk("idle_valid", 32'(out_valid), 0);
        in_I = 8'b0010_0100;
        exp_q.push_back(3'd5);
        for (int c = 1; c <= 7; c++) begin
            cycles(1);
            if (c < 7) chk("t2_early_strobe", 32'(out_strobe), 0);
            else chk("t2_strobe_k7", 32'(out_strobe), 1);
        end
        chk("t2_Y", 32'(out_Y), 5);
        cycles(1);
        chk("t2_hold_valid", 32'(out_valid), 1);
        chk("t2_hold_strobe", 32'(out_strobe), 0);
        ack();
        chk("t2_ack_valid", 32'(out_valid), 0);
        in_I = 0;
        cycles(15);
        gs_seen = 0;
        v_seen = 0;
        in_I = 8'h40;
        cycles(3);
        in_I = 0;
        for (int c = 0; c < 20; c++) begin
            cycles(1);
            gs_seen |= out_GS;
            v_seen |= out_valid;
        end
        chk("t3_glitch_GS", 32'(gs_seen), 0);
        chk("t3_glitch_valid", 32'(v_seen), 0);
        in_I = 8'h02;
        exp_q.push_back(3'd1);
        wait_strobe("t4_strobe_timeout");
        ack();
        chk("t4_ack_valid", 32'(out_valid), 0);
        s0 = strobes;
        cycles(50);
        chk("t4_no_repeat", 32'(strobes - s0), 0);
        chk("t4_held_GS", 32'(out_GS), 1);
        in_I = 0;
        cycles(15);
        in_I = 8'h02;
        exp_q.push_back(3'd1);
        wait_strobe("t4_repress_timeout");
        cycles(1);
        ack();
        in_I = 0;
        cycles(15);
        in_I = 8'h04;
        exp_q.push_back(3'd2);
        wait_strobe("t5_strobe_timeout");
        cycles(1);
        in_I = 8'h84;
        cycles(15);
        chk("t5_GS", 32'(out_GS), 1);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_Y_frozen", 32'(out_Y), 2);
        ack();
        chk("t5_ack_valid", 32'(out_valid), 0);
        in_I = 0;
        cycles(15);
        in_I = 8'h08;
        exp_q.push_back(3'd3);
        wait_strobe("t6_strobe_timeout");
        cycles(2);
        chk("t6_hold_valid", 32'(out_valid), 1);
        EN = 0;
        cycles(1);
        chk("t6_en_valid", 32'(out_valid), 0);
        chk("t6_en_strobe", 32'(out_strobe), 0);
        chk("t6_en_Y", 32'(out_Y), 0);
        chk("t6_en_GS_kept", 32'(out_GS), 1);
        in_I = 0;
        cycles(15);
        EN = 1;
        cycles(3);
        chk("t6_reenable_valid", 32'(out_valid), 0);
        in_I = 8'h10;
        exp_q.push_back(3'd4);
        wait_strobe("t6_rst_strobe_timeout");
        #1 rst_n = 0;
        #1;
        chk("t6_rst_Y", 32'(out_Y), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_strobe", 32'(out_strobe), 0);
        chk("t6_rst_GS", 32'(out_GS), 0);
        in_I = 0;
        @(negedge clk) rst_n = 1;
        s0 = strobes;
        cycles(20);
        chk("t6_no_replay", 32'(strobes - s0), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);
        chk("total_strobes", 32'(strobes), 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
